// File: rtl/res_buf_arbiter_if.sv
// Lane-to-result-buffer bus: per-lane valid/ready/data on one side, buffer write port on the other.
// The arbiter connects through the slave modport; the producer/buffer side uses master.
interface res_buf_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*BIT_DEPTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         buf_wr_en;
    logic [ADDR_WIDTH-1:0]        buf_wr_addr;
    logic [BIT_DEPTH-1:0]         buf_data_in;

    modport master (
        output req_valid, req_data,
        input  req_ready, buf_wr_en, buf_wr_addr, buf_data_in
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, buf_wr_en, buf_wr_addr, buf_data_in
    );
endinterface

// File: rtl/res_buf_arbiter.sv
// Round-robin arbiter that serialises PE-lane results into the single-port result buffer,
// writing sequential addresses for a pass of programmable length and pulsing done at the end.
module res_buf_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   pass_len,
    output logic                  busy,
    output logic                  done,
    res_buf_arbiter_if.slave      bus
);
    localparam int IDXW = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH:0] LEN_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [IDXW:0]       NUM_REQ_W = (IDXW+1)'(NUM_REQ);
    localparam logic [IDXW-1:0]     LAST_LANE = IDXW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH:0]   len_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [IDXW-1:0]       rr_ptr_reg;
    logic                  wr_en_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [BIT_DEPTH-1:0]  data_reg;

    logic [BIT_DEPTH-1:0]  lane_data [NUM_REQ];
    logic [IDXW-1:0]       cand_idx  [NUM_REQ];
    logic                  found;
    logic [IDXW-1:0]       grant_idx;
    logic                  xfer;
    logic                  last_word;
    logic                  start_ok;
    logic [ADDR_WIDTH:0]   len_clamped;
    logic [ADDR_WIDTH:0]   count_inc;

    // cand_idx[k] is the lane examined k-th, counting upward from rr_ptr with wrap.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            logic [IDXW:0] sum;
            assign lane_data[gi] = bus.req_data[gi*BIT_DEPTH +: BIT_DEPTH];
            assign sum           = {1'b0, rr_ptr_reg} + (IDXW+1)'(gi);
            assign cand_idx[gi]  = (sum >= NUM_REQ_W) ? IDXW'(sum - NUM_REQ_W) : sum[IDXW-1:0];
        end
    endgenerate

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[cand_idx[k]]) begin
                found     = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
    end

    // A grant is only ever issued to a valid lane, so a grant in FILL is a handshake.
    assign xfer        = (state_reg == FILL) && found;
    assign count_inc   = count_reg + (ADDR_WIDTH+1)'(1);
    assign last_word   = (count_inc == len_reg);
    assign start_ok    = (state_reg == IDLE) && start;
    assign len_clamped = (pass_len > LEN_MAX) ? LEN_MAX : pass_len;

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = (len_clamped == '0) ? DONE : FILL;
            FILL: if (xfer && last_word) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state_reg == FILL) || (state_reg == DONE);
        done          = (state_reg == DONE);
        bus.req_ready = '0;
        if (xfer) bus.req_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_reg     <= '0;
            count_reg   <= '0;
            wr_ptr_reg  <= '0;
            rr_ptr_reg  <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            data_reg    <= '0;
        end else begin
            wr_en_reg <= xfer;
            if (start_ok) begin
                len_reg    <= len_clamped;
                count_reg  <= '0;
                wr_ptr_reg <= '0;
                rr_ptr_reg <= '0;
            end
            if (xfer) begin
                data_reg    <= lane_data[grant_idx];
                wr_addr_reg <= wr_ptr_reg;
                wr_ptr_reg  <= wr_ptr_reg + ADDR_WIDTH'(1);
                count_reg   <= count_inc;
                rr_ptr_reg  <= (grant_idx == LAST_LANE) ? '0 : grant_idx + IDXW'(1);
            end
        end
    end

    assign bus.buf_wr_en   = wr_en_reg;
    assign bus.buf_wr_addr = wr_addr_reg;
    assign bus.buf_data_in = data_reg;
endmodule

// File: tb/tb_res_buf_arbiter.sv
// Scoreboard bench for res_buf_arbiter: directed passes push expected writes/done pulses,
// a negedge monitor pops and compares whenever the buffer write port or done fires.
module tb_res_buf_arbiter;
    localparam int NR = 4;
    localparam int BD = 8;
    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW:0]   pass_len;
    logic          busy;
    logic          done;

    res_buf_arbiter_if #(.NUM_REQ(NR), .BIT_DEPTH(BD), .ADDR_WIDTH(AW)) bus ();

    res_buf_arbiter #(.NUM_REQ(NR), .BIT_DEPTH(BD), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pass_len (pass_len),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+BD-1:0] exp_q [$];
    int               exp_done_cnt = 0;

    logic [7:0] lane_mem [NR][1024];
    int         lane_head [NR];
    int         lane_tail [NR];

    logic          obs_busy, obs_done, obs_wr_en;
    logic [AW-1:0] obs_addr;
    logic [BD-1:0] obs_data;
    logic [NR-1:0] obs_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int addr, input int data);
        exp_q.push_back({AW'(addr), BD'(data)});
    endtask

    task automatic lane_clear();
        for (int i = 0; i < NR; i++) begin
            lane_head[i] = 0;
            lane_tail[i] = 0;
        end
    endtask

    task automatic lane_push(input int i, input int d);
        lane_mem[i][lane_tail[i]] = BD'(d);
        lane_tail[i]++;
    endtask

    // One clock cycle: present lane fronts under mask, record outputs at negedge, retire handshakes.
    task automatic drive_cycle(input logic [NR-1:0] mask);
        logic [NR-1:0]    v;
        logic [NR*BD-1:0] d;
        logic [NR-1:0]    hs;
        for (int i = 0; i < NR; i++) begin
            v[i]         = mask[i] && (lane_head[i] < lane_tail[i]);
            d[i*BD +: BD] = (lane_head[i] < lane_tail[i]) ? lane_mem[i][lane_head[i]] : 8'h00;
        end
        bus.req_valid = v;
        bus.req_data  = d;
        @(negedge clk);
        obs_busy  = busy;
        obs_done  = done;
        obs_wr_en = bus.buf_wr_en;
        obs_addr  = bus.buf_wr_addr;
        obs_data  = bus.buf_data_in;
        obs_ready = bus.req_ready;
        hs        = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (hs[i]) lane_head[i]++;
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        pass_len = (AW+1)'(len);
        drive_cycle('0);
        start    = 1'b0;
    endtask

    task automatic check_done_then_idle(input string name);
        drive_cycle('0);
        chk({name, "_done"}, 32'(obs_done), 32'd1);
        chk({name, "_busy_in_done"}, 32'(obs_busy), 32'd1);
        drive_cycle('0);
        chk({name, "_done_low"}, 32'(obs_done), 32'd0);
        chk({name, "_busy_low"}, 32'(obs_busy), 32'd0);
    endtask

    // Monitor: every write and every done pulse is matched against the scoreboard.
    initial begin
        @(negedge clk);
        forever begin
            @(negedge clk);
            chk("ready_onehot_valid", 32'($onehot0(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0)), 32'd1);
            if (bus.buf_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", 32'(bus.buf_wr_addr), 32'hFFFF_FFFF);
                end else begin
                    logic [AW+BD-1:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.buf_wr_addr), 32'(e[AW+BD-1:BD]));
                    chk("wr_data", 32'(bus.buf_data_in), 32'(e[BD-1:0]));
                end
            end
            if (done === 1'b1) begin
                chk("done_expected", 32'(exp_done_cnt > 0), 32'd1);
                chk("writes_left_at_done", 32'(exp_q.size()), 32'd0);
                if (exp_done_cnt > 0) exp_done_cnt--;
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        pass_len      = '0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        lane_clear();

        // Reset state
        @(posedge clk);
        #1;
        drive_cycle('0);
        drive_cycle(4'hF);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        chk("rst_done", 32'(obs_done), 32'd0);
        chk("rst_wr_en", 32'(obs_wr_en), 32'd0);
        chk("rst_addr", 32'(obs_addr), 32'd0);
        chk("rst_data", 32'(obs_data), 32'd0);
        chk("rst_ready", 32'(obs_ready), 32'd0);
        rst_n = 1'b1;
        drive_cycle('0);

        // Single lane 2, five words
        lane_clear();
        for (int k = 0; k < 5; k++) begin
            lane_push(2, 8'h10 + k);
            push_exp(k, 8'h10 + k);
        end
        exp_done_cnt++;
        do_start(5);
        chk("t1_busy_at_start", 32'(obs_busy), 32'd0);
        for (int c = 0; c < 5; c++) begin
            drive_cycle(4'b0100);
            if (c == 0) chk("t1_busy_rise", 32'(obs_busy), 32'd1);
            chk("t1_ready", 32'(obs_ready), 32'b0100);
        end
        check_done_then_idle("t1");

        // All lanes valid: fair rotation 0,1,2,3,0,1,2,3
        lane_clear();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NR; i++) lane_push(i, 8'hA0 + i);
        for (int j = 0; j < 8; j++) push_exp(j, 8'hA0 + (j % 4));
        exp_done_cnt++;
        do_start(8);
        for (int c = 0; c < 8; c++) begin
            drive_cycle(4'hF);
            chk("t2_grant", 32'(obs_ready), 32'(1 << (c % 4)));
        end
        check_done_then_idle("t2");

        // Sparse valid on lanes 1 and 3; lane 3 stalls holding 0x31 and 0x32
        begin
            logic [NR-1:0] masks [9];
            masks = '{4'h0, 4'hA, 4'h8, 4'h0, 4'hA, 4'hA, 4'h2, 4'h0, 4'h8};
            lane_clear();
            for (int k = 1; k <= 3; k++) begin
                lane_push(1, 8'h10 + k);
                lane_push(3, 8'h30 + k);
            end
            push_exp(0, 8'h11); push_exp(1, 8'h31); push_exp(2, 8'h12);
            push_exp(3, 8'h32); push_exp(4, 8'h13); push_exp(5, 8'h33);
            exp_done_cnt++;
            do_start(6);
            for (int c = 0; c < 9; c++) drive_cycle(masks[c]);
            check_done_then_idle("t3");
        end

        // Zero-length pass
        lane_clear();
        exp_done_cnt++;
        do_start(0);
        check_done_then_idle("t4_len0");

        // Oversized pass_len clamps to the full buffer depth
        lane_clear();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 256; k++) lane_push(i, i * 64 + k);
        for (int j = 0; j < 1024; j++) push_exp(j, (j % 4) * 64 + j / 4);
        exp_done_cnt++;
        do_start(1024 + 7);
        for (int c = 0; c < 1024; c++) drive_cycle(4'hF);
        chk("t5_last_addr", 32'(obs_addr), 32'd1022);
        check_done_then_idle("t5");

        // start during FILL and during DONE is ignored
        lane_clear();
        for (int k = 0; k < 6; k++) lane_push(0, 8'h50 + k);
        for (int k = 0; k < 4; k++) push_exp(k, 8'h50 + k);
        exp_done_cnt++;
        do_start(4);
        drive_cycle(4'b0001);
        start = 1'b1; pass_len = 11'd9;
        drive_cycle(4'b0001);
        start = 1'b0;
        drive_cycle(4'b0001);
        drive_cycle(4'b0001);
        start = 1'b1; pass_len = 11'd3;
        drive_cycle(4'b0001);
        start = 1'b0;
        chk("t6_done", 32'(obs_done), 32'd1);
        drive_cycle(4'b0001);
        chk("t6_busy_after_done_start", 32'(obs_busy), 32'd0);
        drive_cycle('0);
        chk("t6_no_refill", 32'(obs_wr_en), 32'd0);

        // Reset after 3 of 10 writes aborts; next pass restarts at address 0
        lane_clear();
        for (int k = 0; k < 10; k++) lane_push(1, 8'h70 + k);
        for (int k = 0; k < 3; k++) push_exp(k, 8'h70 + k);
        do_start(10);
        for (int c = 0; c < 3; c++) drive_cycle(4'b0010);
        rst_n = 1'b0;
        drive_cycle('0);
        rst_n = 1'b1;
        drive_cycle(4'b0010);
        chk("t7_busy", 32'(obs_busy), 32'd0);
        chk("t7_done", 32'(obs_done), 32'd0);
        chk("t7_wr_en", 32'(obs_wr_en), 32'd0);
        chk("t7_addr", 32'(obs_addr), 32'd0);
        chk("t7_data", 32'(obs_data), 32'd0);
        chk("t7_ready", 32'(obs_ready), 32'd0);
        push_exp(0, 8'h73);
        push_exp(1, 8'h74);
        exp_done_cnt++;
        do_start(2);
        drive_cycle(4'b0010);
        drive_cycle(4'b0010);
        check_done_then_idle("t7_restart");

        drive_cycle('0);
        drive_cycle('0);
        chk("final_writes_pending", 32'(exp_q.size()), 32'd0);
        chk("final_done_pending", 32'(exp_done_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
